// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns single-cycle CPU data-memory accesses into handshaked
// bus transactions and holds the pipeline until the bus answers.
// Optional macro DMEM_TIMEOUT_EN adds a response timeout with a sticky err flag.
module dmem_bus_bridge #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_mread,
    input  logic          cpu_mwrite,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_stall,
    output logic [31:0]   memory_addr,
    output logic          memory_rden,
    output logic          memory_wren,
    input  logic [31:0]   memory_read_val,
    output logic [31:0]   memory_write_val,
    input  logic          memory_response,
    output logic          err
);

    // The bus data path is fixed at 32 bits; reject other widths at elaboration.
    if (DW != 32 || TIMEOUT < 1) begin : g_param_check
        $error("dmem_bus_bridge: DW must be 32 and TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] din_q, din_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [31:0]   bus_addr;
    logic          cpu_req;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign cpu_req  = cpu_mread | cpu_mwrite;
    assign bus_addr = BASE_ADDR + (32'(a_q) << 2);

    // Stall is combinational so the request cycle itself already holds the pipe;
    // it is also forced low while reset is asserted.
    assign cpu_stall = rst_n & cpu_req & (state_q != ST_DONE);
    assign cpu_dout  = dout_q;

`ifdef DMEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic and bus outputs; bus address/data are only driven while
    // a transaction is in ISSUE or WAIT and read as zero otherwise.
    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        din_d            = din_q;
        wr_d             = wr_q;
        dout_d           = dout_q;
        memory_rden      = 1'b0;
        memory_wren      = 1'b0;
        memory_addr      = '0;
        memory_write_val = '0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d            = cnt_q;
        err_d            = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    a_d     = cpu_a;
                    din_d   = cpu_din;
                    // A write wins when both strobes are high.
                    wr_d    = cpu_mwrite;
                    state_d = ST_ISSUE;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_ISSUE, ST_WAIT: begin
                memory_addr      = bus_addr;
                memory_write_val = wr_q ? din_q : '0;
                if (state_q == ST_ISSUE) begin
                    memory_rden = ~wr_q;
                    memory_wren = wr_q;
                end
                if (memory_response) begin
                    if (!wr_q) begin
                        dout_d = memory_read_val;
                    end
                    state_d = ST_DONE;
                end else begin
`ifdef DMEM_TIMEOUT_EN
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        if (!wr_q) begin
                            dout_d = 32'hDEAD_BEEF;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Bridges the CPU data-memory port (word address, read/write strobes) to the external handshaked memory bus (memory_addr/rden/wren/read_val/write_val/response).
- Sits directly downstream of the datapath's data-memory access point and feeds the external memory.
- Converts single-cycle CPU accesses into multi-cycle bus transactions and stalls the pipeline until the bus completes.

Parameters:
- AW, 8, CPU word-address width.
- DW, 32, data width (bus is fixed at 32; DW must equal 32).
- BASE_ADDR, 32'h0000_0000, byte base address added to every bus address.
- TIMEOUT, 64, cycles to wait for memory_response before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_a  in  AW  CPU word address.
- cpu_din  in  DW  CPU write data.
- cpu_mread  in  1  CPU read request (level).
- cpu_mwrite  in  1  CPU write request (level).
- cpu_dout  out  DW  read data returned to CPU.
- cpu_stall  out  1  hold pipeline while high.
- memory_addr  out  32  bus byte address.
- memory_rden  out  1  bus read strobe.
- memory_wren  out  1  bus write strobe.
- memory_read_val  in  32  bus read data, valid with memory_response.
- memory_write_val  out  32  bus write data.
- memory_response  in  1  bus completion pulse.
- err  out  1  sticky bus-timeout flag (tied 0 without the feature).

Behaviour:
- Reset: one clock `clk`; asynchronous active-low reset `rst_n`. Asserting rst_n low forces state IDLE immediately. All outputs go to 0 (cpu_dout=0, cpu_stall=0, memory_addr=0, memory_rden=0, memory_wren=0, memory_write_val=0, err=0).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On cpu_mread|cpu_mwrite, latch cpu_a, cpu_din and the access kind; go to ISSUE.
  - If both strobes are high, the access is a write.
  - cpu_stall is combinationally high in this cycle: cpu_stall = (cpu_mread|cpu_mwrite) && state!=DONE.
- ISSUE:
  - Assert memory_rden or memory_wren for exactly one cycle.
  - memory_addr = BASE_ADDR + {latched_a, 2'b00}, truncated to 32 bits.
  - memory_write_val = latched din for writes, 0 for reads.
  - If memory_response is high in this cycle, go to DONE; otherwise go to WAIT.
- WAIT:
  - Strobes are low; memory_addr and memory_write_val are held stable.
  - On memory_response: for a read, capture memory_read_val into cpu_dout; go to DONE.
- DONE:
  - cpu_stall is low for exactly one cycle so the CPU advances.
  - memory_addr and memory_write_val return to 0.
  - Go to IDLE. A request seen in the following IDLE cycle is a new transaction.
- Latency: minimum 2 stall cycles (response in the ISSUE cycle); otherwise 2 + N, where N is the number of WAIT cycles.
- cpu_dout holds the last read value until the next read completes. Writes never change cpu_dout.
- memory_response in IDLE or DONE is ignored.
- If the request drops mid-transaction, the transaction still completes. The DONE cycle still occurs, with cpu_stall low.
- Reset during ISSUE/WAIT: the transaction is aborted. A response arriving after reset release is ignored, because the FSM is in IDLE.
- memory_rden and memory_wren are never high together.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - If it reaches TIMEOUT without a response, go to DONE. For a read, cpu_dout = 32'hDEAD_BEEF.
  - err is set and stays set until reset.
- Without the macro: no counter; WAIT lasts indefinitely; err is constant 0.

Test Plan:
- Read, immediate response: cpu_mread=1, cpu_a=8'h04, response in ISSUE with read_val=32'h1234_5678. Expected: rden pulse with memory_addr=32'h10; stall high for 2 cycles; cpu_dout=32'h1234_5678 in DONE.
- Write, 3-cycle wait: cpu_mwrite=1, cpu_a=8'hFF, cpu_din=32'hCAFE_F00D, response 3 cycles after ISSUE. Expected: wren pulse with memory_addr=32'h3FC and write_val stable through WAIT; stall high for 5 cycles; cpu_dout unchanged.
- Both strobes high: cpu_mread=cpu_mwrite=1. Expected: wren only, rden stays 0.
- Reset in WAIT: rst_n low, then a late response after release. Expected: all outputs 0 immediately; state IDLE; late response causes no DONE cycle and no cpu_dout change.
- Back-to-back reads at addresses 1 and 2. Expected: two separate rden pulses, one DONE cycle between them; cpu_dout shows each value in turn.
- DMEM_TIMEOUT_EN with TIMEOUT=4: read with no response. Expected: DONE after 4 cycles; cpu_dout=32'hDEAD_BEEF; err=1 and sticky.
